// File: rtl/taylor_coeff_loader.sv
// Taylor-series coefficient table and streamer feeding the MAC coefficient FIFO.
// Optional TAYLOR_LOADER_HORNER_EN: stream coefficients in descending (Horner) order.
module taylor_coeff_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int FUNC_BITS  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tbl_we_i,
  input  logic [FUNC_BITS-1:0]  tbl_func_i,
  input  logic [ADDR_LINES-1:0] tbl_idx_i,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  output logic                  tbl_err_o,
  input  logic                  start_i,
  input  logic [FUNC_BITS-1:0]  func_sel_i,
  input  logic [ADDR_LINES-1:0] taylor_length_i,
  input  logic                  full_i,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic                  wr_en_coeff_o,
  output logic                  last_coeff_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = 1 << (FUNC_BITS + ADDR_LINES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [FUNC_BITS-1:0]    r_func;
  logic [ADDR_LINES-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]   r_coeff;
  logic                    r_err;
  logic                    w_start_ok;
  logic                    w_tbl_wr;
  logic                    w_write;
  logic                    w_at_end;
  logic [ADDR_LINES-1:0]   w_first_idx;
  logic [ADDR_LINES-1:0]   w_stop_idx;
  logic [ADDR_LINES-1:0]   w_step_idx;

`ifdef TAYLOR_LOADER_HORNER_EN
  assign w_first_idx = taylor_length_i;
  assign w_stop_idx  = '0;
  assign w_step_idx  = r_idx - ADDR_LINES'(1);
`else
  logic [ADDR_LINES-1:0]   r_len;

  always_ff @(posedge clk_i) begin
    if (rst_i)           r_len <= '0;
    else if (w_start_ok) r_len <= taylor_length_i;
  end

  assign w_first_idx = '0;
  assign w_stop_idx  = r_len;
  assign w_step_idx  = r_idx + ADDR_LINES'(1);
`endif

  assign w_start_ok = (r_state == S_IDLE) && start_i;
  assign w_tbl_wr   = (r_state == S_IDLE) && tbl_we_i && !start_i && !rst_i;
  assign w_write    = (r_state == S_WRITE) && !full_i;
  assign w_at_end   = (r_idx == w_stop_idx);

  // Table storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_tbl_wr) r_mem[{tbl_func_i, tbl_idx_i}] <= tbl_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_func  <= '0;
      r_idx   <= '0;
      r_coeff <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= tbl_we_i && ((r_state != S_IDLE) || start_i);
      if (w_start_ok) begin
        r_func <= func_sel_i;
        r_idx  <= w_first_idx;
      end else if (w_write && !w_at_end) begin
        r_idx <= w_step_idx;
      end
      if (r_state == S_READ) r_coeff <= r_mem[{r_func, r_idx}];
    end
  end

  always_comb begin
    w_next        = r_state;
    wr_en_coeff_o = 1'b0;
    last_coeff_o  = 1'b0;
    done_o        = 1'b0;
    busy_o        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        wr_en_coeff_o = !full_i;
        last_coeff_o  = w_at_end;
        if (!full_i) w_next = w_at_end ? S_DONE : S_READ;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign coeff_o   = r_coeff;
  assign tbl_err_o = r_err;

endmodule

// File: tb/tb_taylor_coeff_loader.sv
// Self-checking bench for taylor_coeff_loader: per-cycle expectations derived from a table model.
module tb_taylor_coeff_loader;
  localparam int DW   = 32;
  localparam int AL   = 5;
  localparam int FB   = 2;
  localparam int MAXR = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_we;
  logic [FB-1:0] tbl_func;
  logic [AL-1:0] tbl_idx;
  logic [DW-1:0] tbl_data;
  logic          tbl_err;
  logic          start;
  logic [FB-1:0] func_sel;
  logic [AL-1:0] tlen;
  logic          full;
  logic [DW-1:0] coeff;
  logic          wr_en;
  logic          last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [1<<FB][1<<AL];
  bit            fs  [MAXR];
  bit            ew  [MAXR];
  bit            eb  [MAXR];
  bit            ed  [MAXR];
  bit            ee  [MAXR];
  bit            ecv [MAXR];
  bit            el  [MAXR];
  logic [DW-1:0] ec  [MAXR];

  taylor_coeff_loader #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .FUNC_BITS(FB)) dut (
    .clk_i(clk), .rst_i(rst), .tbl_we_i(tbl_we), .tbl_func_i(tbl_func),
    .tbl_idx_i(tbl_idx), .tbl_data_i(tbl_data), .tbl_err_o(tbl_err),
    .start_i(start), .func_sel_i(func_sel), .taylor_length_i(tlen),
    .full_i(full), .coeff_o(coeff), .wr_en_coeff_o(wr_en),
    .last_coeff_o(last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic write_tbl(input int f, input int i, input logic [DW-1:0] d);
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_func = FB'(f); tbl_idx = AL'(i); tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    model[f][i] = d;
  endtask

  // stall_mode: 0 none, 1 full high for rel cycles slo..shi, 2 random.
  // we_rel: -1 no table write, -2 random cycle within the load, else that rel cycle.
  task automatic do_load(input int f, input int len, input int stall_mode, input int slo,
                         input int shi, input int we_rel, input string name);
    int t;
    int done_rel;
    int idx;
    int wr;
    for (int r = 0; r < MAXR; r++) begin
      ew[r] = 0; eb[r] = 0; ed[r] = 0; ee[r] = 0; ecv[r] = 0; el[r] = 0; ec[r] = '0;
      case (stall_mode)
        1:       fs[r] = (r >= slo && r <= shi);
        2:       fs[r] = (r < 1500) && ($urandom_range(0, 2) == 0);
        default: fs[r] = 0;
      endcase
    end
    t = 2;
    for (int k = 0; k <= len; k++) begin
`ifdef TAYLOR_LOADER_HORNER_EN
      idx = len - k;
`else
      idx = k;
`endif
      while (fs[t]) begin
        ecv[t] = 1; ec[t] = model[f][idx]; el[t] = (k == len); t++;
      end
      ecv[t] = 1; ec[t] = model[f][idx]; el[t] = (k == len); ew[t] = 1;
      t += 2;
    end
    done_rel = t - 1;
    ed[done_rel] = 1;
    for (int r = 1; r <= done_rel; r++) eb[r] = 1;
    wr = (we_rel == -2) ? int'($urandom_range(0, done_rel)) : we_rel;
    if (wr >= 0) ee[wr + 1] = 1;

    for (int r = 0; r <= done_rel + 2; r++) begin
      @(posedge clk); #1;
      if (r == 0) begin
        start = 1'b1; func_sel = FB'(f); tlen = AL'(len);
      end else begin
        start    = (r <= done_rel) ? 1'($urandom_range(0, 1)) : 1'b0;
        func_sel = FB'($urandom);
        tlen     = AL'($urandom);
      end
      full = fs[r];
      tbl_we = (r == wr);
      tbl_func = FB'(f); tbl_idx = AL'($urandom); tbl_data = $urandom;
      @(negedge clk);
      checks++;
      if (wr_en !== ew[r]) begin
        errors++; $display("FAIL %s wr_en rel=%0d got=%b exp=%b", name, r, wr_en, ew[r]);
      end
      checks++;
      if (busy !== eb[r]) begin
        errors++; $display("FAIL %s busy rel=%0d got=%b exp=%b", name, r, busy, eb[r]);
      end
      checks++;
      if (done !== ed[r]) begin
        errors++; $display("FAIL %s done rel=%0d got=%b exp=%b", name, r, done, ed[r]);
      end
      checks++;
      if (tbl_err !== ee[r]) begin
        errors++; $display("FAIL %s tbl_err rel=%0d got=%b exp=%b", name, r, tbl_err, ee[r]);
      end
      if (ecv[r]) begin
        checks++;
        if (coeff !== ec[r]) begin
          errors++; $display("FAIL %s coeff rel=%0d got=%h exp=%h", name, r, coeff, ec[r]);
        end
        checks++;
        if (last !== el[r]) begin
          errors++; $display("FAIL %s last rel=%0d got=%b exp=%b", name, r, last, el[r]);
        end
      end
    end
    start = 1'b0; full = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({coeff, wr_en, last, busy, done, tbl_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs got coeff=%h we=%b last=%b busy=%b done=%b err=%b exp all 0",
               coeff, wr_en, last, busy, done, tbl_err);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_program();
    for (int i = 0; i < 4; i++) write_tbl(1, i, DW'(32'h10 + i));
    do_load(1, 3, 0, 0, 0, -1, "program");
  endtask

  task automatic test_backpressure();
    do_load(1, 3, 1, 4, 6, -1, "backpressure");
  endtask

  task automatic test_boundaries();
    do_load(3, 0, 0, 0, 0, -1, "len0");
    do_load(2, 31, 0, 0, 0, -1, "len31");
    do_load(0, 31, 2, 0, 0, -1, "len31_stall");
  endtask

  task automatic test_tbl_busy();
    do_load(2, 5, 0, 0, 0, 3, "we_busy");
    do_load(2, 5, 0, 0, 0, -1, "we_busy_reload");
    do_load(1, 3, 0, 0, 0, 0, "we_with_start");
    do_load(1, 3, 0, 0, 0, -1, "we_with_start_reload");
  endtask

  task automatic test_reset_midload();
    logic [DW-1:0] second;
`ifdef TAYLOR_LOADER_HORNER_EN
    second = model[1][2];
`else
    second = model[1][1];
`endif
    @(posedge clk); #1;
    start = 1'b1; func_sel = 2'd1; tlen = 5'd3; full = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = (r == 5);
      @(negedge clk);
      if (r == 4) begin
        checks++;
        if (wr_en !== 1'b1 || coeff !== second) begin
          errors++;
          $display("FAIL rst_mid second_write got we=%b coeff=%h exp we=1 coeff=%h", wr_en, coeff, second);
        end
      end
      if (r >= 6) begin
        checks++;
        if ({coeff, wr_en, last, busy, done, tbl_err} !== '0) begin
          errors++;
          $display("FAIL rst_mid outputs rel=%0d got coeff=%h we=%b last=%b busy=%b done=%b exp all 0",
                   r, coeff, wr_en, last, busy, done);
        end
      end
    end
    rst = 1'b0;
    do_load(1, 3, 0, 0, 0, -1, "rst_reload");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int f;
      int l;
      f = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 31));
      if (n % 3 == 0) write_tbl(f, int'($urandom_range(0, l)), $urandom);
      do_load(f, l, 2, 0, 0, (n % 2 == 0) ? -2 : -1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; tbl_we = 1'b0; tbl_func = '0; tbl_idx = '0; tbl_data = '0;
    start = 1'b0; func_sel = '0; tlen = '0; full = 1'b0;
    test_reset();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 32; i++) write_tbl(f, i, $urandom);
    test_program();
    test_backpressure();
    test_boundaries();
    test_tbl_busy();
    test_reset_midload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
